// File: rtl/button_cmd_filter_pkg.sv
// Shared constants for the three-button command filter.
// Channel indices also give the bit order of o_btn_held.
package button_cmd_filter_pkg;

   localparam int BTN_CNT                 = 3;
   localparam int BTN_PAUSE               = 0;
   localparam int BTN_CFG_1               = 1;
   localparam int BTN_CFG_2               = 2;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level.
// press_o is the 0->1 commit strobe; the parent registers it as the output pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic held_o,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic RAW_IDLE = BTN_ACTIVE_LOW;

   logic          sync1_q, sync2_q;
   logic          state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level;
   logic          commit;

   // XOR with the idle raw level yields pressed = 1 for either polarity.
   assign level = sync2_q ^ RAW_IDLE;

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      commit  = 1'b0;
      if (level == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         state_d = level;
         cnt_d   = '0;
         commit  = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= RAW_IDLE;
         sync2_q <= RAW_IDLE;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign held_o  = state_q;
   assign press_o = commit & level;

endmodule

// File: rtl/button_cmd_filter.sv
// Debounces pause/cfg_1/cfg_2 buttons into one-cycle command pulses.
// cfg_1 wins over a same-cycle cfg_2 press; the losing press is dropped.
module button_cmd_filter
   import button_cmd_filter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_pause,
   input  logic       i_btn_cfg_1,
   input  logic       i_btn_cfg_2,
   output logic       o_cmd_toggle_pause,
   output logic       o_cmd_load_cfg_1,
   output logic       o_cmd_load_cfg_2,
   output logic [2:0] o_btn_held
);

   logic [BTN_CNT-1:0] raw_btn;
   logic [BTN_CNT-1:0] press;
   logic [BTN_CNT-1:0] held;
   logic [BTN_CNT-1:0] cmd_q, cmd_d;

   assign raw_btn = {i_btn_cfg_2, i_btn_cfg_1, i_btn_pause};

   generate
      for (genvar gi = 0; gi < BTN_CNT; gi++) begin : g_chan
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
         ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (raw_btn[gi]),
            .held_o  (held[gi]),
            .press_o (press[gi])
         );
      end
   endgenerate

   always_comb begin
      cmd_d = press;
      if (press[BTN_CFG_1]) begin
         cmd_d[BTN_CFG_2] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q <= '0;
      end else begin
         cmd_q <= cmd_d;
      end
   end

   assign o_cmd_toggle_pause = cmd_q[BTN_PAUSE];
   assign o_cmd_load_cfg_1   = cmd_q[BTN_CFG_1];
   assign o_cmd_load_cfg_2   = cmd_q[BTN_CFG_2];
   assign o_btn_held         = held;

endmodule

// File: tb/tb_button_cmd_filter.sv
// Directed bench: stimulus pushes expected pulse cycles, a negedge monitor
// pops and compares them; debounced levels are checked inline.
module tb_button_cmd_filter;

   localparam int D   = 4;
   localparam int LAT = D + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_btn_pause, i_btn_cfg_1, i_btn_cfg_2;
   logic       o_cmd_toggle_pause, o_cmd_load_cfg_1, o_cmd_load_cfg_2;
   logic [2:0] o_btn_held;

   typedef struct {
      int ch;
      int cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;
   logic [2:0] mon_p;

   button_cmd_filter #(
      .DEBOUNCE_CYCLES (D),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_btn_pause        (i_btn_pause),
      .i_btn_cfg_1        (i_btn_cfg_1),
      .i_btn_cfg_2        (i_btn_cfg_2),
      .o_cmd_toggle_pause (o_cmd_toggle_pause),
      .o_cmd_load_cfg_1   (o_cmd_load_cfg_1),
      .o_cmd_load_cfg_2   (o_cmd_load_cfg_2),
      .o_btn_held         (o_btn_held)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %b (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic expect_pulse(input int ch, input int at);
      exp_t e;
      e.ch  = ch;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_p = {o_cmd_load_cfg_2, o_cmd_load_cfg_1, o_cmd_toggle_pause};
         if (mon_p[1] && mon_p[2]) begin
            checks++;
            errors++;
            $display("FAIL cfg_exclusive: both cfg pulses high at cycle %0d", cyc);
         end
         for (int c = 0; c < 3; c++) begin
            if (mon_p[c]) begin
               int  idx;
               bit  found;
               found = 1'b0;
               idx   = 0;
               for (int i = 0; i < exp_q.size(); i++) begin
                  if (!found && exp_q[i].ch == c) begin
                     found = 1'b1;
                     idx   = i;
                  end
               end
               checks++;
               if (!found) begin
                  errors++;
                  $display("FAIL pulse_ch%0d: unexpected pulse at cycle %0d, none expected", c, cyc);
               end else begin
                  if (exp_q[idx].cyc != cyc) begin
                     errors++;
                     $display("FAIL pulse_ch%0d: pulse at cycle %0d expected cycle %0d", c, cyc, exp_q[idx].cyc);
                  end else begin
                     $display("ok   pulse_ch%0d: at cycle %0d", c, cyc);
                  end
                  exp_q.delete(idx);
               end
            end
         end
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL pulse_ch%0d: missing pulse, expected at cycle %0d, now %0d",
                        exp_q[i].ch, exp_q[i].cyc, cyc);
               exp_q.delete(i);
            end
         end
      end
   end

   initial begin
      int c0;
      rst         = 1'b1;
      i_btn_pause = 1'b1;
      i_btn_cfg_1 = 1'b1;
      i_btn_cfg_2 = 1'b1;
      tick(3);
      check("reset_held", o_btn_held, 3'b000);
      check("reset_cmd", {o_cmd_load_cfg_2, o_cmd_load_cfg_1, o_cmd_toggle_pause}, 3'b000);
      rst    = 1'b0;
      mon_en = 1'b1;
      tick(8);

      // Clean press on pause
      i_btn_pause = 1'b0;
      expect_pulse(0, cyc + LAT);
      tick(20);
      check("clean_held", o_btn_held, 3'b001);
      i_btn_pause = 1'b1;
      tick(10);
      check("clean_release", o_btn_held, 3'b000);

      // Bouncing cfg_1: 0,1,0,1 then settle at 0
      i_btn_cfg_1 = 1'b0; tick(1);
      i_btn_cfg_1 = 1'b1; tick(1);
      i_btn_cfg_1 = 1'b0; tick(1);
      i_btn_cfg_1 = 1'b1; tick(1);
      i_btn_cfg_1 = 1'b0;
      expect_pulse(1, cyc + LAT);
      tick(15);
      check("bounce_held", o_btn_held, 3'b010);
      i_btn_cfg_1 = 1'b1;
      tick(10);
      check("bounce_release", o_btn_held, 3'b000);

      // 3-cycle glitch on cfg_2
      i_btn_cfg_2 = 1'b0;
      tick(3);
      i_btn_cfg_2 = 1'b1;
      tick(10);
      check("glitch_held", o_btn_held, 3'b000);

      // Press then release on cfg_2
      i_btn_cfg_2 = 1'b0;
      expect_pulse(2, cyc + LAT);
      tick(12);
      check("cfg2_held", o_btn_held, 3'b100);
      i_btn_cfg_2 = 1'b1;
      tick(LAT - 1);
      check("cfg2_release_early", o_btn_held, 3'b100);
      tick(1);
      check("cfg2_release_done", o_btn_held, 3'b000);
      tick(6);

      // Simultaneous cfg_1 and cfg_2: only cfg_1 pulses
      i_btn_cfg_1 = 1'b0;
      i_btn_cfg_2 = 1'b0;
      expect_pulse(1, cyc + LAT);
      tick(12);
      check("simul_held", o_btn_held, 3'b110);
      i_btn_cfg_1 = 1'b1;
      i_btn_cfg_2 = 1'b1;
      tick(10);
      check("simul_release", o_btn_held, 3'b000);

      // Pause alongside cfg_2: both pulse
      i_btn_pause = 1'b0;
      i_btn_cfg_2 = 1'b0;
      expect_pulse(0, cyc + LAT);
      expect_pulse(2, cyc + LAT);
      tick(12);
      check("pause_cfg2_held", o_btn_held, 3'b101);
      i_btn_pause = 1'b1;
      i_btn_cfg_2 = 1'b1;
      tick(10);

      // Reset mid-debounce with pause held through release
      i_btn_pause = 1'b0;
      c0 = cyc;
      tick(4);
      rst = 1'b1;
      #1;
      check("midrst_held", o_btn_held, 3'b000);
      check("midrst_cmd", {o_cmd_load_cfg_2, o_cmd_load_cfg_1, o_cmd_toggle_pause}, 3'b000);
      tick(3);
      rst = 1'b0;
      expect_pulse(0, cyc + LAT);
      $display("info reset released at cycle %0d (press driven at %0d)", cyc, c0);
      tick(12);
      check("midrst_after", o_btn_held, 3'b001);
      i_btn_pause = 1'b1;
      tick(10);
      check("final_held", o_btn_held, 3'b000);

      mon_en = 1'b0;
      foreach (exp_q[i]) begin
         checks++;
         errors++;
         $display("FAIL pulse_ch%0d: never seen, expected at cycle %0d", exp_q[i].ch, exp_q[i].cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_cmd_filter.md
BUTTON_CMD_FILTER -- requirements
Module: button_cmd_filter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, giving the number of consecutive stable synchronized samples required to accept a level change; legal range is at least 2.
REQ-002 SHALL have parameter BTN_ACTIVE_LOW, default 1; when set to 1, a raw input level of 0 means pressed.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have port i_btn_pause, input, width 1: raw, asynchronous, bouncing pause button.
REQ-006 SHALL have port i_btn_cfg_1, input, width 1: raw button requesting configuration 1.
REQ-007 SHALL have port i_btn_cfg_2, input, width 1: raw button requesting configuration 2.
REQ-008 SHALL have port o_cmd_toggle_pause, output, width 1: one-cycle press pulse for the pause button.
REQ-009 SHALL have port o_cmd_load_cfg_1, output, width 1: one-cycle press pulse for configuration 1.
REQ-010 SHALL have port o_cmd_load_cfg_2, output, width 1: one-cycle press pulse for configuration 2.
REQ-011 SHALL have port o_btn_held, output, width 3: debounced pressed levels as {cfg_2, cfg_1, pause}.

Function
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchronizer, then normalize it to pressed=1 according to BTN_ACTIVE_LOW.
REQ-013 Each channel SHALL hold a debounced state register and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-014 When the synchronized level equals the debounced state, the counter SHALL clear to 0 on that edge.
REQ-015 When the levels differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-016 When the levels differ and the counter equals DEBOUNCE_CYCLES-1, the channel SHALL load the synchronized level into the debounced state and clear the counter; the counter SHALL never wrap.
REQ-017 A debounced 0->1 commit SHALL register a press pulse on the same edge; the pulse SHALL be high for exactly one cycle.
REQ-018 A debounced 1->0 commit (release) SHALL produce no pulse.
REQ-019 Latency: with a clean press first sampled at edge 1, the pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-020 A pressed glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no o_btn_held change.
REQ-021 Holding a button SHALL produce a single pulse, with no auto-repeat.
REQ-022 If cfg_1 and cfg_2 pulses would assert in the same cycle, o_cmd_load_cfg_1 SHALL assert and the cfg_2 pulse SHALL be dropped, not deferred.
REQ-023 o_cmd_load_cfg_1 and o_cmd_load_cfg_2 SHALL never be high together.
REQ-024 The pause channel SHALL be independent of the cfg channels; simultaneous pulses with a cfg channel SHALL both appear.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-026 On rst assertion, the synchronizer flops SHALL take the released level, and the debounced states, counters, all o_cmd_* outputs and o_btn_held SHALL go to 0 immediately, without waiting for clk.
REQ-027 A reset applied mid-debounce SHALL discard the partial count.
REQ-028 A button held through reset release SHALL produce one pulse DEBOUNCE_CYCLES+2 cycles after deassertion.

Structure
REQ-029 Package defs SHALL hold BTN_CNT=3, the channel index constants BTN_PAUSE=0, BTN_CFG_1=1, BTN_CFG_2=2, and DEBOUNCE_CYCLES_DEFAULT.
REQ-030 Sub-module btn_debounce SHALL implement one channel (synchronizer, counter, state, pulse) and SHALL be instantiated BTN_CNT times.
REQ-031 The cfg priority arbitration and the output registers SHALL reside in button_cmd_filter.

Verification (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-032 Clean press: i_btn_pause 1->0 held for 20 cycles -> o_cmd_toggle_pause high for exactly 1 cycle, 6 cycles after the first sampling edge; o_btn_held[0]=1.
REQ-033 Bounce: i_btn_cfg_1 toggles 0,1,0,1 each cycle, then is held at 0 -> exactly one o_cmd_load_cfg_1 pulse, 6 cycles after the final settle.
REQ-034 Glitch/release: a 3-cycle low pulse on i_btn_cfg_2 -> no pulse; press then release -> one pulse only, and o_btn_held[2] returns to 0 six cycles after release.
REQ-035 Simultaneous: i_btn_cfg_1 and i_btn_cfg_2 pressed on the same edge -> only o_cmd_load_cfg_1 pulses; o_btn_held=3'b110.
REQ-036 Reset mid-operation: press, assert rst at count 2, release rst while still pressed -> no pulse before reset; one pulse 6 cycles after rst deasserts.
